serial_adder_ctrl: RTL and testbench

//   Bit-serial adder sequencer. Instantiates one full_adder (ports a, b, cin,
//   sum, carry) and adds two W-bit operands over W clocks, one bit per cycle,
//   LSB first. Start/busy/done handshake. Sits between a requester and the

---
 rtl/serial_adder_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full_adder, W cycles per add, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum_out,
  output logic         cout_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (W > 1) ? W - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a_sh;
  logic [W-1:0]   r_b_sh;
  logic [RW-1:0]  r_res_sh;
  logic           r_c;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_sum;
  logic           r_cout;
  logic           r_busy;
  logic           r_done;
  logic           w_sum;
  logic           w_carry;
  logic [W-1:0]   w_res_nxt;
  logic [RW-1:0]  w_res_keep;

  full_adder u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .cin   (r_c),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // Partial result lives in the top bits; new bit enters at the MSB.
  generate
    if (W == 1) begin : g_w1
      assign w_res_nxt  = w_sum;
      assign w_res_keep = r_res_sh;
    end else begin : g_wn
      assign w_res_nxt  = {w_sum, r_res_sh};
      assign w_res_keep = w_res_nxt[W-1:1];
    end
  endgenerate

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_c     <= cin_in;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_c      <= w_carry;
          r_res_sh <= w_res_keep;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_res_nxt;
            r_cout  <= w_carry;
            r_state <= S_DONE;
            r_done  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= r_c ^ w_carry;
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum_out  = r_sum;
  assign cout_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: timeline model for W=4 plus directed
// literal checks, and an exhaustive sweep of a W=2 instance.
module tb_serial_adder_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         ovf;

  logic         start2 = 1'b0;
  logic [1:0]   a2 = '0;
  logic [1:0]   b2 = '0;
  logic         cin2 = 1'b0;
  logic         busy2, done2, cout2;
  logic [1:0]   sum2;
  logic         ovf2;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_in(a), .b_in(b), .cin_in(cin),
    .busy(busy), .done(done),
    .sum_out(sum), .cout_out(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder_ctrl #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a_in(a2), .b_in(b2), .cin_in(cin2),
    .busy(busy2), .done(done2),
    .sum_out(sum2), .cout_out(cout2)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf  = 1'b0;
  assign ovf2 = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edges elapsed since acceptance; 0 = idle, W+1 = result cycle.
  int m_t = 0;
  int m_sum = 0, m_cout = 0, m_ovf = 0;
  int p_sum = 0, p_cout = 0, p_ovf = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_sum = 0; m_cout = 0; m_ovf = 0;
    end else if (m_t == 0) begin
      if (start) begin
        int t, sa, sb, v;
        t      = int'(a) + int'(b) + int'(cin);
        p_sum  = t % (1 << W);
        p_cout = t / (1 << W);
        sa     = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
        sb     = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
        v      = sa + sb + int'(cin);
        p_ovf  = (v > (1 << (W - 1)) - 1 || v < -(1 << (W - 1))) ? 1 : 0;
        m_t    = 1;
      end
    end else if (m_t <= W) begin
      m_t++;
      if (m_t == W + 1) begin
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else begin
      m_t = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), (m_t != 0) ? 1 : 0);
      chk("done", int'(done), (m_t == W + 1) ? 1 : 0);
      chk("sum_out", int'(sum), m_sum);
      chk("cout_out", int'(cout), m_cout);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", int'(ovf), m_ovf);
`endif
    end
  end

  task automatic go(input int av, input int bv, input int cv);
    @(posedge clk); #1;
    a = W'(av); b = W'(bv); cin = cv[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int av, input int bv, input int cv,
                     input int es, input int ec);
    go(av, bv, cv);
    a = ~a; b = ~b;
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    wait_done();
    chk("lit_sum", int'(sum), es);
    chk("lit_cout", int'(cout), ec);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int nd;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
    chk_en = 1'b1;

    run(3, 5, 0, 8, 0);
    run(15, 1, 0, 0, 1);
    run(7, 7, 1, 15, 0);

    // Start held high: two accepts in 12 edges, mid-run operand change.
    @(posedge clk); #1;
    a = 4'd1; b = 4'd1; cin = 1'b0; start = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) begin a = 4'd9; b = 4'd6; end
      if (i == 5) begin a = 4'd1; b = 4'd1; end
      if (done) nd++;
    end
    @(posedge clk); #1 start = 1'b0;
    chk("held_start_dones", nd, 2);
    chk("held_start_sum", int'(sum), 2);
    repeat (3) @(negedge clk);

    // Reset during the second RUN cycle aborts the add.
    go(9, 3, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sum", int'(sum), 0);
    chk("abort_cout", int'(cout), 0);
    @(posedge clk); #1 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run(2, 2, 0, 4, 0);

`ifdef SERIAL_ADD_OVF_EN
    run(7, 1, 0, 8, 0);
    chk("lit_ovf_7_1", int'(ovf), 1);
    run(15, 1, 0, 0, 1);
    chk("lit_ovf_15_1", int'(ovf), 0);
`else
    run(6, 9, 1, 0, 1);
`endif

    for (int i = 0; i < 32; i++) begin
      int k;
      @(posedge clk); #1;
      a2 = i[1:0]; b2 = i[3:2]; cin2 = i[4]; start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      k = 0;
      while (!done2 && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("w2_sum", int'({cout2, sum2}),
          (i & 3) + ((i >> 2) & 3) + ((i >> 4) & 1));
      @(posedge clk);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
